// File: rtl/lcd_pkg.sv
// lcd_pkg: sequencer state encoding and default sizing shared by the LCD command sequencer files.
package lcd_pkg;

    localparam int LCD_LAST_SEL   = 33;
    localparam int LCD_LOOKUP_LAT = 1;
    localparam int SEL_W          = 6;
    localparam int LAT_W          = 3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        WAIT_LKP = 3'd2,
        SEND     = 3'd3,
        DONE     = 3'd4
    } lcd_state_t;

endpackage

// File: rtl/lcd_sel_counter.sv
// lcd_sel_counter: command-table index that steps 0..LAST_SEL, wraps after the last entry and can be cleared.
module lcd_sel_counter
    import lcd_pkg::*;
#(
    parameter int LAST_SEL = LCD_LAST_SEL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             incr,
    output logic [SEL_W-1:0] sel,
    output logic             last
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(LAST_SEL);

    // Treat anything at or above the final index as last so the index can never run past it.
    assign last = (sel >= LAST_IDX);

    // Clear wins over increment; incrementing from the last entry wraps back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel <= '0;
        end else if (clear) begin
            sel <= '0;
        end else if (incr) begin
            sel <= last ? '0 : sel + SEL_W'(1);
        end
    end

endmodule

// File: rtl/lcd_seq_ctrl.sv
// lcd_seq_ctrl: walks the command table one index at a time, waits out the table latency,
// and hands each byte to the writer with a valid/ready handshake.
module lcd_seq_ctrl
    import lcd_pkg::*;
#(
    parameter int LAST_SEL   = LCD_LAST_SEL,
    parameter int LOOKUP_LAT = LCD_LOOKUP_LAT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             repeat_en,
    input  logic             abort,
    input  logic             lookup_ready,
    input  logic [7:0]       lookup_data,
    output logic [SEL_W-1:0] sel_out,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             done
);

    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LOOKUP_LAT - 1);

    lcd_state_t       state;
    logic             pending;
    logic [LAT_W-1:0] lat_cnt;
    logic             abort_hit;
    logic             launch;
    logic             accept;
    logic             sel_last;

    // Decode the events that move the index: abort and frame launch clear it, an accepted byte advances it.
    always_comb begin
        abort_hit = abort && (state != IDLE);
        launch    = (state == IDLE) && pending && lookup_ready;
        accept    = (state == SEND) && tx_valid && tx_ready;
    end

    lcd_sel_counter #(
        .LAST_SEL (LAST_SEL)
    ) u_sel (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (abort_hit || launch),
        .incr  (accept && !abort_hit),
        .sel   (sel_out),
        .last  (sel_last)
    );

    // Frame sequencer with registered handshake and status outputs; abort overrides everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pending  <= 1'b0;
            lat_cnt  <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort_hit) begin
                state    <= IDLE;
                pending  <= 1'b0;
                tx_valid <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (launch) begin
                            state   <= ADDR;
                            pending <= 1'b0;
                            busy    <= 1'b1;
                        end else if (start) begin
                            pending <= 1'b1;
                        end
                    end
                    ADDR: begin
                        if (lookup_ready) begin
                            lat_cnt <= LAT_LOAD;
                            state   <= WAIT_LKP;
                        end
                    end
                    WAIT_LKP: begin
                        if (!lookup_ready) begin
                            state <= ADDR;
                        end else if (lat_cnt == '0) begin
                            tx_data  <= lookup_data;
                            tx_valid <= 1'b1;
                            state    <= SEND;
                        end else begin
                            lat_cnt <= lat_cnt - LAT_W'(1);
                        end
                    end
                    SEND: begin
                        if (accept) begin
                            tx_valid <= 1'b0;
                            if (sel_last) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= ADDR;
                            end
                        end
                    end
                    DONE: begin
                        if (repeat_en && lookup_ready) begin
                            state <= ADDR;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
